pcie_rx_drain: RTL

- Far-end consumer of the transaction block's four 10-bit output lanes.
- Pops words from the four lane FIFOs (empty/pop interface, registered read data) under round-robin arbitration and merges them into one valid/ready stream tagged with the source lane.
- Keeps per-lane delivered-word counters, readable with an idx/req port.
- Provides the receive-side traffic counts that the verification bench compares against the transmit-side counters.

---
 rtl/pcie_rx_drain.sv | 112 +++++++++++
 1 files changed

// File: rtl/pcie_rx_drain.sv
// pcie_rx_drain: round-robin drain of four lane FIFOs into one tagged valid/ready stream with per-lane counters.
// Optional destination check on captured words: PCIE_RX_ROUTE_CHECK_EN.
module pcie_rx_drain #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] lane_data0,
    input  logic [DATA_W-1:0] lane_data1,
    input  logic [DATA_W-1:0] lane_data2,
    input  logic [DATA_W-1:0] lane_data3,
    input  logic              lane_empty0,
    input  logic              lane_empty1,
    input  logic              lane_empty2,
    input  logic              lane_empty3,
    output logic              pop0,
    output logic              pop1,
    output logic              pop2,
    output logic              pop3,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        lane_out,
    output logic              valid_out,
    input  logic              ready_in,
    input  logic [1:0]        idx,
    input  logic              req,
    output logic [CNT_W-1:0]  counter_out,
    output logic              cnt_valid,
    output logic              idle,
    output logic              route_err
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    logic [DATA_W-1:0] lane_data [4];
    logic [DATA_W+1:0] buf_q [2];
    logic [CNT_W-1:0]  cnt [4];
    logic [3:0]        empty, pops;
    logic [1:0]        rr_ptr, tag, sel, count;
    logic              rd_ptr, wr_ptr, inflight, deq, enq, can_issue, issue, route_ok;
    state_t            state;

    assign lane_data[0] = lane_data0;
    assign lane_data[1] = lane_data1;
    assign lane_data[2] = lane_data2;
    assign lane_data[3] = lane_data3;
    assign empty = {lane_empty3, lane_empty2, lane_empty1, lane_empty0};

    assign valid_out = count != 2'd0;
    assign {lane_out, data_out} = buf_q[rd_ptr];
    assign deq = valid_out & ready_in;
    // Words already owed to the buffer (stored + in flight) must leave room after this cycle's dequeue.
    assign can_issue = enable && ({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, deq});
    assign issue = can_issue & ~&empty;
    assign pops = (issue & reset) ? 4'b0001 << sel : 4'b0000;
    assign {pop3, pop2, pop1, pop0} = pops;

    always_comb begin
        sel = rr_ptr;
        for (int k = 3; k >= 0; k--)
            if (!empty[rr_ptr + 2'(k)]) sel = rr_ptr + 2'(k);
    end

`ifdef PCIE_RX_ROUTE_CHECK_EN
    assign route_ok = lane_data[tag][DATA_W-1:DATA_W-2] == tag;
`else
    assign route_ok = 1'b1;
    assign route_err = 1'b0;
`endif
    assign enq = inflight & route_ok;

    assign state = inflight ? FETCH : (count != 2'd0 ? HOLD : IDLE);
    assign idle = (state == IDLE) & (&empty) & enable;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            tag         <= '0;
            inflight    <= 1'b0;
            count       <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            counter_out <= '0;
            cnt_valid   <= 1'b0;
            for (int i = 0; i < 2; i++) buf_q[i] <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
`ifdef PCIE_RX_ROUTE_CHECK_EN
            route_err   <= 1'b0;
`endif
        end else begin
            inflight <= issue;
            if (issue) begin
                rr_ptr <= sel + 2'd1;
                tag    <= sel;
            end
            if (enq) begin
                buf_q[wr_ptr] <= {tag, lane_data[tag]};
                wr_ptr        <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr        <= ~rd_ptr;
                cnt[lane_out] <= cnt[lane_out] + 1'b1;
            end
            count     <= count + {1'b0, enq} - {1'b0, deq};
            cnt_valid <= req;
            if (req) counter_out <= cnt[idx];
`ifdef PCIE_RX_ROUTE_CHECK_EN
            if (inflight & ~route_ok) route_err <= 1'b1;
`endif
        end
    end
endmodule
